// File: rtl/input_conditioner_pkg.sv
// Shared defaults for the input conditioner slice.
package input_conditioner_pkg;

    localparam int unsigned DEFAULT_WAIT_TIME     = 3;
    localparam int unsigned DEFAULT_COUNTER_WIDTH = 3;

endpackage : input_conditioner_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;

    always_comb begin
        sync0_d = din;
        sync1_d = sync0_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    assign dout = sync1_q;

endmodule : sync_2ff

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one noisy asynchronous input.
// faultactive freezes the debounced level while the synchronizer keeps running.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned WAIT_TIME     = DEFAULT_WAIT_TIME,
    parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisysignal,
    input  logic faultactive,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    logic                     sync1;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     conditioned_q, conditioned_d;
    logic                     positiveedge_q, positiveedge_d;
    logic                     negativeedge_q, negativeedge_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (noisysignal),
        .dout    (sync1)
    );

    // Counter only advances while the synchronized level disagrees with the output;
    // it commits after WAIT_TIME further disagreeing cycles, so it never wraps.
    always_comb begin
        counter_d      = counter_q;
        conditioned_d  = conditioned_q;
        positiveedge_d = 1'b0;
        negativeedge_d = 1'b0;
        if (faultactive || (sync1 == conditioned_q)) begin
            counter_d = '0;
        end else if (counter_q == COUNTER_WIDTH'(WAIT_TIME)) begin
            counter_d      = '0;
            conditioned_d  = sync1;
            positiveedge_d = sync1;
            negativeedge_d = !sync1;
        end else begin
            counter_d = counter_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q      <= '0;
            conditioned_q  <= 1'b0;
            positiveedge_q <= 1'b0;
            negativeedge_q <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            conditioned_q  <= conditioned_d;
            positiveedge_q <= positiveedge_d;
            negativeedge_q <= negativeedge_d;
        end
    end

    assign conditioned  = conditioned_q;
    assign positiveedge = positiveedge_q;
    assign negativeedge = negativeedge_q;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench: directed latency/debounce/fault scenarios plus randomized
// stimulus compared against a streak-counting reference model.
module tb_input_conditioner;

    localparam int unsigned WAIT_TIME = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic noisysignal = 1'b0;
    logic faultactive = 1'b0;
    logic conditioned, positiveedge, negativeedge;

    int checks = 0;
    int errors = 0;

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .noisysignal  (noisysignal),
        .faultactive  (faultactive),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge)
    );

    always #10 clk = ~clk;

    // Reference: the debouncer sees the input two samples late; the level flips once
    // WAIT_TIME+1 consecutive late samples disagree with it.
    logic [1:0] m_hist;
    int         m_streak;
    logic       m_cond, m_pos, m_neg;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist   <= 2'b00;
            m_streak <= 0;
            m_cond   <= 1'b0;
            m_pos    <= 1'b0;
            m_neg    <= 1'b0;
        end else begin
            m_hist <= {m_hist[0], noisysignal};
            m_pos  <= 1'b0;
            m_neg  <= 1'b0;
            if (faultactive || (m_hist[1] == m_cond)) begin
                m_streak <= 0;
            end else if (m_streak + 1 > int'(WAIT_TIME)) begin
                m_streak <= 0;
                m_cond   <= m_hist[1];
                m_pos    <= m_hist[1];
                m_neg    <= !m_hist[1];
            end else begin
                m_streak <= m_streak + 1;
            end
        end
    end

    task automatic test_reset();
        reset_n     = 1'b0;
        noisysignal = 1'b1;
        faultactive = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({conditioned, positiveedge, negativeedge} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold: got %b%b%b expected 000", conditioned, positiveedge, negativeedge);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (conditioned !== (e == 6) || positiveedge !== (e == 6)) begin
                errors++;
                $display("FAIL reset_release edge %0d: cond=%b pos=%b expected %b", e, conditioned, positiveedge, e == 6);
            end
        end
    endtask

    task automatic test_debounce();
        // conditioned is 1 here; glitches must be rejected
        @(posedge clk); #3;
        fork
            begin
                for (int t = 0; t < 10; t++) begin
                    #7 noisysignal = ~noisysignal;
                end
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (conditioned !== 1'b1 || positiveedge !== 1'b0 || negativeedge !== 1'b0) begin
                        errors++;
                        $display("FAIL debounce cycle %0d: cond=%b pos=%b neg=%b expected 1 0 0", c, conditioned, positiveedge, negativeedge);
                    end
                end
            end
        join
        checks++;
        if (noisysignal !== 1'b1) begin
            errors++;
            $display("FAIL debounce_end_level: got %b expected 1", noisysignal);
        end
    endtask

    task automatic test_falling();
        @(negedge clk);
        noisysignal = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (negativeedge !== (e == 6) || conditioned !== (e != 6) || positiveedge !== 1'b0) begin
                errors++;
                $display("FAIL falling edge %0d: cond=%b neg=%b pos=%b", e, conditioned, negativeedge, positiveedge);
            end
        end
        #20;
        checks++;
        if (negativeedge !== 1'b0 || conditioned !== 1'b0) begin
            errors++;
            $display("FAIL falling_after: neg=%b cond=%b expected 0 0", negativeedge, conditioned);
        end
    endtask

    task automatic test_rising();
        @(negedge clk);
        noisysignal = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (positiveedge !== (e == 6) || conditioned !== (e == 6) || negativeedge !== 1'b0) begin
                errors++;
                $display("FAIL rising edge %0d: cond=%b pos=%b neg=%b", e, conditioned, positiveedge, negativeedge);
            end
        end
        #20;
        checks++;
        if (positiveedge !== 1'b0 || conditioned !== 1'b1) begin
            errors++;
            $display("FAIL rising_after: pos=%b cond=%b expected 0 1", positiveedge, conditioned);
        end
    endtask

    task automatic test_fault();
        @(negedge clk);
        noisysignal = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (conditioned !== 1'b0) begin
            errors++;
            $display("FAIL fault_precondition: cond=%b expected 0", conditioned);
        end
        faultactive = 1'b1;
        noisysignal = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({conditioned, positiveedge, negativeedge} !== 3'b000) begin
                errors++;
                $display("FAIL fault_hold cycle %0d: got %b%b%b expected 000", c, conditioned, positiveedge, negativeedge);
            end
        end
        @(negedge clk);
        faultactive = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (conditioned !== (e == 4) || positiveedge !== (e == 4)) begin
                errors++;
                $display("FAIL fault_release edge %0d: cond=%b pos=%b expected %b", e, conditioned, positiveedge, e == 4);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        @(negedge clk);
        noisysignal = 1'b0;
        repeat (8) @(negedge clk);
        noisysignal = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (conditioned !== (e == 6)) begin
                errors++;
                $display("FAIL reset_mid_count edge %0d: cond=%b expected %b", e, conditioned, e == 6);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) noisysignal = ~noisysignal;
            if ($urandom_range(0, 29) == 0) faultactive = ~faultactive;
            @(posedge clk); #1;
            checks++;
            if (conditioned !== m_cond || positiveedge !== m_pos || negativeedge !== m_neg) begin
                errors++;
                $display("FAIL random cycle %0d: dut=%b%b%b model=%b%b%b", c,
                         conditioned, positiveedge, negativeedge, m_cond, m_pos, m_neg);
            end
            checks++;
            if (positiveedge === 1'b1 && negativeedge === 1'b1) begin
                errors++;
                $display("FAIL random_both_edges cycle %0d: pos=1 neg=1 expected not both", c);
            end
        end
        faultactive = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_falling();
        test_rising();
        test_fault();
        test_reset_mid_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_input_conditioner
